// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues one synchronous imem read per accepted PC and queues
// {pc, word} pairs for the decoder, counting the in-flight read against capacity.
module instr_fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [ADDR_WIDTH-1:0]    pc_in,
    input  logic                     pc_valid,
    output logic                     pc_ready,
    input  logic                     flush,
    output logic                     imem_rd_en,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_data,
    output logic [DATA_WIDTH-1:0]    instr_out,
    output logic [ADDR_WIDTH-1:0]    instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    logic                  fire, push, pop;
    logic [OW-1:0]         committed;

    // The outstanding read reserves a slot, so a full queue can never overflow.
    assign committed  = occ_q + OW'(inflight_q);
    assign pc_ready   = !flush && (committed < DEPTH_C);
    assign fire       = pc_valid && pc_ready;
    assign imem_rd_en = fire;
    assign imem_addr  = fire ? pc_in : '0;

    assign push        = inflight_q && !flush;
    assign instr_valid = (occ_q != '0);
    assign pop         = instr_valid && instr_ready;

    assign instr_out = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc  = instr_valid ? pc_mem[rd_ptr_q]   : '0;
    assign occupancy = occ_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        inflight_d = fire;
        pc_d       = fire ? pc_in : pc_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            inflight_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge Clock) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_data;
            pc_mem[wr_ptr_q]   <= pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed checks of instr_fetch_queue against a queue-based
// model of fetch acceptance, one-cycle memory latency, flush and reset.
module tb_instr_fetch_queue;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic [AW-1:0] pc_in;
    logic          pc_valid;
    logic          pc_ready;
    logic          flush;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [OW-1:0] occupancy;

    instr_fetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .pc_in(pc_in), .pc_valid(pc_valid),
        .pc_ready(pc_ready), .flush(flush), .imem_rd_en(imem_rd_en),
        .imem_addr(imem_addr), .imem_data(imem_data), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .occupancy(occupancy)
    );

    always #5 Clock = ~Clock;

    function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
        return 32'hA000_0000 + a;
    endfunction

    // Synchronous instruction memory with one-cycle read latency.
    always @(posedge Clock) begin
        if (imem_rd_en === 1'b1) imem_data <= mem_word(imem_addr);
    end

    int n_assert = 0;
    int n_fail   = 0;
    int dut_fires = 0;

    logic [AW-1:0] exp_q[$];
    int            infl_m = 0;
    logic [AW-1:0] pend_m = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle(output bit fired);
        bit rdy_m, fire_m;
        @(negedge Clock);
        rdy_m  = !flush && ((exp_q.size() + infl_m) < DEPTH);
        fire_m = pc_valid && rdy_m;
        chk("pc_ready", pc_ready, rdy_m);
        chk("imem_rd_en", imem_rd_en, fire_m);
        if (fire_m) chk("imem_addr", imem_addr, pc_in);
        if (imem_rd_en === 1'b1) dut_fires++;
        chk("instr_valid", instr_valid, exp_q.size() != 0);
        chk("occupancy", occupancy, exp_q.size());
        if (exp_q.size() != 0) begin
            chk("instr_pc", instr_pc, exp_q[0]);
            chk("instr_out", instr_out, mem_word(exp_q[0]));
        end
        @(posedge Clock);
        if (flush) begin
            exp_q.delete();
            infl_m = 0;
        end else begin
            if (exp_q.size() != 0 && instr_ready) void'(exp_q.pop_front());
            if (infl_m != 0) exp_q.push_back(pend_m);
            infl_m = fire_m ? 1 : 0;
            pend_m = pc_in;
        end
        #1;
        fired = fire_m;
    endtask

    task automatic drive(input bit v, input bit r, input bit f);
        bit fired;
        pc_valid    = v;
        instr_ready = r;
        flush       = f;
        cycle(fired);
        if (fired) pc_in = pc_in + 1;
    endtask

    initial begin
        int fetched;
        int target;
        int budget;
        bit fired;

        Reset_n = 1'b0; pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_in = '0;
        #12;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_occ", occupancy, 0);
        chk("rst_rd_en", imem_rd_en, 1'b0);
        chk("rst_out", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        #1 Reset_n = 1'b1;
        @(posedge Clock); #1;

        // Stream: one word per cycle after two cycles of latency.
        pc_in = 0;
        for (int i = 0; i < 12; i++) drive(1, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0);

        // Backpressure: capacity includes the in-flight read.
        pc_in = 'h100;
        dut_fires = 0;
        for (int i = 0; i < 6; i++) drive(1, 0, 0);
        chk("bp_accepts", dut_fires, 4);
        chk("bp_occ", occupancy, 4);
        for (int i = 0; i < 8; i++) drive(1, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0);

        // Flush with three queued and one in flight.
        pc_in = 'h200;
        for (int i = 0; i < 4; i++) drive(1, 0, 0);
        chk("fl_pre_occ", occupancy, 3);
        drive(1, 0, 1);
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", instr_valid, 1'b0);
        pc_in = 'h40;
        drive(1, 1, 0);
        drive(0, 1, 0);
        chk("fl_new_pc", instr_pc, 'h40);
        for (int i = 0; i < 3; i++) drive(0, 1, 0);

        // Simultaneous push and pop with three queued and one in flight.
        pc_in = 'h300;
        for (int i = 0; i < 4; i++) drive(1, 0, 0);
        chk("pp_pre_occ", occupancy, 3);
        drive(0, 1, 0);
        chk("pp_occ", occupancy, 3);
        for (int i = 0; i < 5; i++) drive(0, 1, 0);

        // Random readiness across several pointer wraps.
        pc_in = 'h400;
        fetched = 0;
        target = 3 * DEPTH + 1;
        budget = 0;
        while (budget < 400 && !(fetched == target && exp_q.size() == 0 && infl_m == 0)) begin
            pc_valid    = (fetched < target) && ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            flush       = 1'b0;
            cycle(fired);
            if (fired) begin
                pc_in = pc_in + 1;
                fetched++;
            end
            budget++;
        end
        chk("wrap_done", (fetched == target && exp_q.size() == 0) ? 1 : 0, 1);

        // Asynchronous reset between edges, mid-stream.
        pc_in = 'h480;
        for (int i = 0; i < 3; i++) drive(1, 0, 0);
        pc_valid = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_valid", instr_valid, 1'b0);
        chk("arst_occ", occupancy, 0);
        exp_q.delete();
        infl_m = 0;
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        pc_in = 'h500;
        drive(1, 1, 0);
        drive(0, 0, 0);
        chk("arst_first_pc", instr_pc, 'h500);
        chk("arst_first_data", instr_out, mem_word('h500));
        for (int i = 0; i < 3; i++) drive(0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
